urv_dmem_responder: RTL and testbench
=====================================

Name: urv_dmem_responder

Overview:
Responder end of the uRV data-memory interface. Accepts single-cycle load and store strobes from the CPU and performs the access on an internal word-organised RAM. Returns a one-cycle load_done or store_done after a configurable number of wait states. Sits beside the CPU in the uRV subsystem; out-of-window and protocol errors are flagged to system logic.

Parameters:
g_size_words, 4096, RAM depth in 32-bit words; power of two, minimum 16.
g_base_addr, 32'h0000_0000, byte base address of the RAM window; aligned to g_size_words*4.
g_wait_states, 0, extra cycles between request and done; legal range 0..15.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_n_i  in  1  reset; asynchronous, active-low.
dm_addr_i  in  32  byte address; valid in the strobe cycle only.
dm_data_s_i  in  32  store data; valid in the strobe cycle only.
dm_data_select_i  in  4  byte-lane enables for stores; bit n maps to bits [8n+7:8n].
dm_store_i  in  1  store strobe, one cycle.
dm_load_i  in  1  load strobe, one cycle.
dm_data_l_o  out  32  load data; valid only while dm_load_done_o=1, otherwise 0.
dm_load_done_o  out  1  one-cycle load completion.
dm_store_done_o  out  1  one-cycle store completion.
busy_o  out  1  a request is outstanding.
err_o  out  1  sticky error flag.
err_clr_i  in  1  clears err_o; a new error in the same cycle wins.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, any outstanding request discarded with no done pulse. RAM contents are not reset.
- Window hit: dm_addr_i - g_base_addr < g_size_words*4. Word index is (dm_addr_i - g_base_addr)[log2(g_size_words)+1:2]. Bits [1:0] are ignored; there is no misalignment check.
- FSM states IDLE, WAIT, DONE.
  - IDLE: on a strobe, capture addr, data, select, kind and hit. Go to WAIT if g_wait_states>0, else DONE. Set busy_o=1 from the next cycle.
  - WAIT: a 4-bit counter loads g_wait_states-1 and decrements. At 0, go to DONE.
  - DONE: pulse the matching done output for exactly one cycle, then return to IDLE with busy_o=0.
- Latency: strobe in cycle N, done in cycle N+1+g_wait_states. A new strobe is accepted in the done cycle's following cycle. The minimum request spacing is therefore 2+g_wait_states cycles.
- Stores: the RAM write happens in the DONE cycle and affects only the enabled byte lanes. A select of 4'b0000 writes nothing but still returns store_done.
- Loads: the RAM is read synchronously. The read address is issued so that the data is registered and presented in the DONE cycle.
- Out-of-window access:
  - done is still returned, so the CPU never hangs.
  - A store is suppressed.
  - A load returns 32'h0.
  - err_o is set.
- Strobe while busy: ignored (no capture, no extra done), and err_o is set.
- dm_load_i and dm_store_i together in IDLE: treated as a store only, and err_o is set.
- Load after store to the same word returns the new data; no bypass is needed, because the store completes before the next request is accepted.

Decomposition:
- Shared include (alongside the existing uRV defines): FSM state encodings, plus the wait-state counter width (4).
- Sub-module urv_dmem_ram: single-port synchronous RAM with a 4-bit byte-write enable and registered read. Parameter g_size_words. Keep it inferable as block RAM.
- The responder holds the FSM, the capture registers, window decode and error logic.

Test Plan:
1. g_wait_states=0. Store 32'hCAFEBABE to 0x10 with select 4'hF, then load 0x10 → store_done at N+1; load_done with data 32'hCAFEBABE one cycle after issue; err_o=0.
2. Byte lanes. Store 32'h11223344 to 0x20 with select 4'hF, then 32'hAABBCCDD with select 4'b0101, then load → 32'h11BB33DD.
3. g_wait_states=3 → done exactly 4 cycles after the strobe; busy_o high for cycles N+1..N+4. A strobe at N+2 is ignored, err_o=1, and only one done pulse occurs.
4. Load from g_base_addr+g_size_words*4 → load_done with data 0 and err_o=1. Then err_clr_i → err_o=0. A store to the same address leaves the RAM unchanged (verified by readback at word 0).
5. Simultaneous dm_load_i and dm_store_i → store performed, only store_done pulses, err_o=1.
6. Assert rst_n_i low while in WAIT → outputs 0 immediately (asynchronous), no done after release. Data from an earlier completed store is still readable.

Source files
------------

// File: rtl/urv_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// urv_dmem_responder_pkg
// Shared definitions for the uRV data-memory responder slice: bus widths,
// FSM state encoding, request kind and the wait-state counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package urv_dmem_responder_pkg;

   localparam int DM_ADDR_W  = 32;
   localparam int DM_DATA_W  = 32;
   localparam int DM_SEL_W   = 4;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_t;

   typedef enum logic {
      KIND_LOAD  = 1'b0,
      KIND_STORE = 1'b1
   } dmem_kind_t;

   // The counter is loaded with one less than the wait-state count because the
   // cycle in which it reaches zero is itself the last wait cycle.
   function automatic logic [WAIT_CNT_W-1:0] wait_preload(input int wait_states);
      if (wait_states > 0) begin
         return WAIT_CNT_W'(wait_states - 1);
      end
      return '0;
   endfunction

endpackage

// File: rtl/urv_dmem_responder_if.sv
// -----------------------------------------------------------------------------
// urv_dmem_responder_if
// uRV data-memory bus between the CPU (master) and the responder (slave).
//   dm_addr        byte address, valid in the strobe cycle
//   dm_data_s      store data, valid in the strobe cycle
//   dm_data_select byte-lane enables for stores
//   dm_store       store strobe (one cycle)
//   dm_load        load strobe (one cycle)
//   dm_data_l      load data, zero unless dm_load_done is high
//   dm_load_done   one-cycle load completion
//   dm_store_done  one-cycle store completion
// -----------------------------------------------------------------------------
interface urv_dmem_responder_if;
   import urv_dmem_responder_pkg::*;

   logic [DM_ADDR_W-1:0] dm_addr;
   logic [DM_DATA_W-1:0] dm_data_s;
   logic [DM_SEL_W-1:0]  dm_data_select;
   logic                 dm_store;
   logic                 dm_load;
   logic [DM_DATA_W-1:0] dm_data_l;
   logic                 dm_load_done;
   logic                 dm_store_done;

   modport master (
      output dm_addr, dm_data_s, dm_data_select, dm_store, dm_load,
      input  dm_data_l, dm_load_done, dm_store_done
   );

   modport slave (
      input  dm_addr, dm_data_s, dm_data_select, dm_store, dm_load,
      output dm_data_l, dm_load_done, dm_store_done
   );

endinterface

// File: rtl/urv_dmem_ram.sv
// -----------------------------------------------------------------------------
// urv_dmem_ram
// Single-port synchronous RAM, 32-bit words, per-byte write enable, registered
// read. Written in the plain form that synthesis maps onto block RAM.
//   clk_i    clock
//   we_i     write enable
//   be_i     byte-lane enables (bit n -> bits [8n+7:8n])
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, one cycle after addr_i
// -----------------------------------------------------------------------------
module urv_dmem_ram #(
   parameter int g_size_words = 4096
) (
   input  logic                            clk_i,
   input  logic                            we_i,
   input  logic [3:0]                      be_i,
   input  logic [$clog2(g_size_words)-1:0] addr_i,
   input  logic [31:0]                     wdata_i,
   output logic [31:0]                     rdata_o
);

   logic [31:0] mem [g_size_words];

   // Byte-lane writes and a registered read share one port. The contents are
   // deliberately never reset.
   always_ff @(posedge clk_i) begin
      for (int lane = 0; lane < 4; lane++) begin
         if (we_i && be_i[lane]) begin
            mem[addr_i][lane*8 +: 8] <= wdata_i[lane*8 +: 8];
         end
      end
      rdata_o <= mem[addr_i];
   end

endmodule

// File: rtl/urv_dmem_responder.sv
// -----------------------------------------------------------------------------
// urv_dmem_responder
// Responder end of the uRV data-memory interface. Captures single-cycle load
// and store strobes, waits g_wait_states cycles, performs the access on an
// internal RAM and returns a one-cycle done pulse.
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   dm         data-memory bus (slave side)
//   err_clr_i  clears the sticky error flag (a new error wins)
//   busy_o     a request is outstanding
//   err_o      sticky error: out-of-window access, strobe while busy, or
//              load and store strobed together
// -----------------------------------------------------------------------------
module urv_dmem_responder
   import urv_dmem_responder_pkg::*;
#(
   parameter int          g_size_words  = 4096,
   parameter logic [31:0] g_base_addr   = 32'h0000_0000,
   parameter int          g_wait_states = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   urv_dmem_responder_if.slave  dm,
   input  logic                 err_clr_i,
   output logic                 busy_o,
   output logic                 err_o
);

   localparam int                    IDX_W        = $clog2(g_size_words);
   localparam logic [31:0]           WINDOW_BYTES = 32'(g_size_words * 4);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD    = wait_preload(g_wait_states);

   dmem_state_t           state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q;
   logic [31:0]           data_q;
   logic [3:0]            sel_q;
   dmem_kind_t            kind_q;
   logic                  hit_q;
   logic                  err_q;

   logic [31:0]           offset_in;
   logic                  hit_in;
   logic                  strobe;
   logic                  capture;
   logic                  err_set;
   logic                  ram_we;
   logic [IDX_W-1:0]      ram_addr;
   logic [31:0]           ram_rdata;

   // Window decode: the subtraction wraps for addresses below the base, so a
   // single unsigned compare covers both ends of the window.
   assign offset_in = dm.dm_addr - g_base_addr;
   assign hit_in    = offset_in < WINDOW_BYTES;
   assign strobe    = dm.dm_load | dm.dm_store;

   // While idle the RAM is addressed straight from the bus so that a load
   // issued with no wait states has its data registered by the DONE cycle;
   // afterwards the captured index holds the read data stable and steers the
   // store in DONE.
   assign ram_addr  = (state_q == ST_IDLE) ? offset_in[IDX_W+1:2] : idx_q;

   urv_dmem_ram #(
      .g_size_words (g_size_words)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .be_i    (sel_q),
      .addr_i  (ram_addr),
      .wdata_i (data_q),
      .rdata_o (ram_rdata)
   );

   // Next-state and output decode. Any strobe outside IDLE is an error and is
   // otherwise ignored. Out-of-window stores still complete on the bus but
   // never reach the RAM, and out-of-window loads return zero.
   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      capture           = 1'b0;
      err_set           = 1'b0;
      ram_we            = 1'b0;
      dm.dm_load_done   = 1'b0;
      dm.dm_store_done  = 1'b0;
      dm.dm_data_l      = '0;
      busy_o            = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (strobe) begin
               capture = 1'b1;
               err_set = (dm.dm_load & dm.dm_store) | ~hit_in;
               if (g_wait_states > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_WAIT: begin
            err_set = strobe;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            err_set = strobe;
            state_d = ST_IDLE;
            if (kind_q == KIND_STORE) begin
               dm.dm_store_done = 1'b1;
               ram_we           = hit_q;
            end else begin
               dm.dm_load_done  = 1'b1;
               dm.dm_data_l     = hit_q ? ram_rdata : '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and error flag. Reset drops any outstanding request
   // without a done pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (err_set) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
      end
   end

   // Request capture. A simultaneous load and store is recorded as a store.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         idx_q  <= '0;
         data_q <= '0;
         sel_q  <= '0;
         kind_q <= KIND_LOAD;
         hit_q  <= 1'b0;
      end else if (capture) begin
         idx_q  <= offset_in[IDX_W+1:2];
         data_q <= dm.dm_data_s;
         sel_q  <= dm.dm_data_select;
         kind_q <= dm.dm_store ? KIND_STORE : KIND_LOAD;
         hit_q  <= hit_in;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_urv_dmem_responder
// Drives two responders sharing one clock and reset: dut0 with no wait states
// at base 0, dut1 with three wait states at base 0x1000. A word-array model
// with sticky-error tracking predicts every completion.
// -----------------------------------------------------------------------------
module tb_urv_dmem_responder;

   localparam int          SIZE  = 16;
   localparam logic [31:0] SPAN  = 32'(SIZE * 4);
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_1000;
   localparam int          WS0   = 0;
   localparam int          WS1   = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        ldD   [2];
   logic        stD   [2];
   logic [31:0] addrD [2];
   logic [31:0] dataD [2];
   logic [3:0]  selD  [2];
   logic        clrD  [2];

   logic busy0, busy1, err0, err1;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] refMem [2][SIZE];
   logic        expErr [2];

   urv_dmem_responder_if ifA ();
   urv_dmem_responder_if ifB ();

   assign ifA.dm_load        = ldD[0];
   assign ifA.dm_store       = stD[0];
   assign ifA.dm_addr        = addrD[0];
   assign ifA.dm_data_s      = dataD[0];
   assign ifA.dm_data_select = selD[0];
   assign ifB.dm_load        = ldD[1];
   assign ifB.dm_store       = stD[1];
   assign ifB.dm_addr        = addrD[1];
   assign ifB.dm_data_s      = dataD[1];
   assign ifB.dm_data_select = selD[1];

   urv_dmem_responder #(
      .g_size_words (SIZE),
      .g_base_addr  (BASE0),
      .g_wait_states(WS0)
   ) dut0 (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .dm        (ifA.slave),
      .err_clr_i (clrD[0]),
      .busy_o    (busy0),
      .err_o     (err0)
   );

   urv_dmem_responder #(
      .g_size_words (SIZE),
      .g_base_addr  (BASE1),
      .g_wait_states(WS1)
   ) dut1 (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .dm        (ifB.slave),
      .err_clr_i (clrD[1]),
      .busy_o    (busy1),
      .err_o     (err1)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] baseOf(input int d);
      return (d == 0) ? BASE0 : BASE1;
   endfunction

   function automatic int wsOf(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic logic rdBusy(input int d);
      return (d == 0) ? busy0 : busy1;
   endfunction

   function automatic logic rdErr(input int d);
      return (d == 0) ? err0 : err1;
   endfunction

   function automatic logic rdLd(input int d);
      return (d == 0) ? ifA.dm_load_done : ifB.dm_load_done;
   endfunction

   function automatic logic rdSt(input int d);
      return (d == 0) ? ifA.dm_store_done : ifB.dm_store_done;
   endfunction

   function automatic logic [31:0] rdData(input int d);
      return (d == 0) ? ifA.dm_data_l : ifB.dm_data_l;
   endfunction

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic drive(input int d, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, input logic clr);
      ldD[d]   = ld;
      stD[d]   = st;
      addrD[d] = a;
      dataD[d] = wd;
      selD[d]  = sel;
      clrD[d]  = clr;
   endtask

   task automatic driveIdle(input int d);
      drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
   endtask

   // One complete transaction from an idle responder: predicts the result
   // from the word model, waits a bounded time for the done pulse and checks
   // latency, done kind, data, busy and the sticky error flag.
   task automatic applyStimulus(input int d, input logic doLoad, input logic doStore,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input logic clr,
                                output logic [31:0] gotData);
      logic [31:0] off;
      logic        hit;
      int          idx;
      logic [31:0] expData;
      int          lat;
      logic        seen;
      logic        busyOk;

      @(negedge clk);
      checkOutput($sformatf("dut%0d_idle_busy", d), 32'(rdBusy(d)), 32'h0);
      checkOutput($sformatf("dut%0d_idle_done", d), {30'h0, rdLd(d), rdSt(d)}, 32'h0);
      checkOutput($sformatf("dut%0d_idle_data", d), rdData(d), 32'h0);
      drive(d, doLoad, doStore, addr, wdata, sel, clr);

      off     = addr - baseOf(d);
      hit     = (off < SPAN);
      idx     = int'(off >> 2);
      expData = 32'h0;
      if (doStore) begin
         if (hit) begin
            for (int l = 0; l < 4; l++) begin
               if (sel[l]) refMem[d][idx][l*8 +: 8] = wdata[l*8 +: 8];
            end
         end
      end else if (hit) begin
         expData = refMem[d][idx];
      end
      if ((doLoad && doStore) || !hit) begin
         expErr[d] = 1'b1;
      end else if (clr) begin
         expErr[d] = 1'b0;
      end

      @(negedge clk);
      driveIdle(d);
      checkOutput($sformatf("dut%0d_err", d), 32'(rdErr(d)), 32'(expErr[d]));

      lat    = 0;
      seen   = 1'b0;
      busyOk = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         if (rdBusy(d) !== 1'b1) busyOk = 1'b0;
         if (rdLd(d) === 1'b1 || rdSt(d) === 1'b1) begin
            lat  = c;
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput($sformatf("dut%0d_done_seen", d), 32'(seen), 32'h1);
      checkOutput($sformatf("dut%0d_latency", d), 32'(lat), 32'(1 + wsOf(d)));
      checkOutput($sformatf("dut%0d_store_done", d), 32'(rdSt(d)), 32'(doStore));
      checkOutput($sformatf("dut%0d_load_done", d), 32'(rdLd(d)), 32'(!doStore));
      checkOutput($sformatf("dut%0d_load_data", d), rdData(d), expData);
      checkOutput($sformatf("dut%0d_busy_hold", d), 32'(busyOk), 32'h1);
      gotData = rdData(d);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] w0;
      logic [31:0] expD;
      logic [31:0] addr;
      logic        both;
      logic        isSt;
      int          r;
      int          extra;

      driveIdle(0);
      driveIdle(1);
      expErr[0] = 1'b0;
      expErr[1] = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", {30'h0, busy1, busy0}, 32'h0);
      checkOutput("reset_err", {30'h0, err1, err0}, 32'h0);
      checkOutput("reset_done", {28'h0, ifB.dm_load_done, ifB.dm_store_done,
                                 ifA.dm_load_done, ifA.dm_store_done}, 32'h0);
      checkOutput("reset_data0", ifA.dm_data_l, 32'h0);
      checkOutput("reset_data1", ifB.dm_data_l, 32'h0);
      #2 rst_n = 1'b1;

      // Give every word a known value through the bus
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < SIZE; w++) begin
            applyStimulus(d, 1'b0, 1'b1, baseOf(d) + 32'(w * 4), $urandom, 4'hF, 1'b0, got);
         end
      end

      // Zero-wait store then load
      applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, got);
      applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, got);
      checkOutput("t1_data", got, 32'hCAFEBABE);
      checkOutput("t1_err", 32'(err0), 32'h0);

      // Byte lanes
      applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, got);
      applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, got);
      applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, got);
      checkOutput("t2_data", got, 32'h11BB33DD);

      // Three wait states with a stray store during WAIT
      @(negedge clk);
      checkOutput("t3_busy_pre", 32'(busy1), 32'h0);
      checkOutput("t3_err_pre", 32'(err1), 32'h0);
      drive(1, 1'b1, 1'b0, BASE1 + 32'h14, 32'h0, 4'h0, 1'b0);
      expD = refMem[1][5];
      @(negedge clk);
      driveIdle(1);
      checkOutput("t3_busy_n1", 32'(busy1), 32'h1);
      @(negedge clk);
      checkOutput("t3_busy_n2", 32'(busy1), 32'h1);
      checkOutput("t3_done_n2", {30'h0, ifB.dm_load_done, ifB.dm_store_done}, 32'h0);
      drive(1, 1'b0, 1'b1, BASE1 + 32'h18, 32'h12345678, 4'hF, 1'b0);
      @(negedge clk);
      driveIdle(1);
      checkOutput("t3_err_stray", 32'(err1), 32'h1);
      checkOutput("t3_busy_n3", 32'(busy1), 32'h1);
      checkOutput("t3_done_n3", {30'h0, ifB.dm_load_done, ifB.dm_store_done}, 32'h0);
      @(negedge clk);
      checkOutput("t3_load_done", 32'(ifB.dm_load_done), 32'h1);
      checkOutput("t3_store_done", 32'(ifB.dm_store_done), 32'h0);
      checkOutput("t3_data", ifB.dm_data_l, expD);
      checkOutput("t3_busy_n4", 32'(busy1), 32'h1);
      expErr[1] = 1'b1;
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ifB.dm_load_done !== 1'b0 || ifB.dm_store_done !== 1'b0 || busy1 !== 1'b0) extra++;
      end
      checkOutput("t3_no_extra_done", 32'(extra), 32'h0);
      applyStimulus(1, 1'b1, 1'b0, BASE1 + 32'h18, 32'h0, 4'h0, 1'b0, got);

      // Load and store together
      applyStimulus(0, 1'b1, 1'b1, 32'h24, 32'h5555AAAA, 4'hF, 1'b0, got);
      checkOutput("t5_err", 32'(err0), 32'h1);
      applyStimulus(0, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, got);
      checkOutput("t5_readback", got, 32'h5555AAAA);

      // Out-of-window load, error clear, suppressed store
      applyStimulus(0, 1'b1, 1'b0, BASE0 + SPAN, 32'h0, 4'h0, 1'b0, got);
      checkOutput("t4_data", got, 32'h0);
      checkOutput("t4_err", 32'(err0), 32'h1);
      @(negedge clk);
      clrD[0] = 1'b1;
      @(negedge clk);
      clrD[0] = 1'b0;
      checkOutput("t4_err_clr", 32'(err0), 32'h0);
      expErr[0] = 1'b0;
      w0 = refMem[0][0];
      applyStimulus(0, 1'b0, 1'b1, BASE0 + SPAN, 32'hDEADBEEF, 4'hF, 1'b0, got);
      applyStimulus(0, 1'b1, 1'b0, BASE0, 32'h0, 4'h0, 1'b0, got);
      checkOutput("t4_word0", got, w0);

      // Randomised traffic against the word model
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
               addr = baseOf(d) + SPAN + 32'($urandom_range(0, 63));
            end else if (r == 1) begin
               addr = baseOf(d) - 32'd4;
            end else begin
               addr = baseOf(d) + 32'($urandom_range(0, SIZE * 4 - 1));
            end
            both = ($urandom_range(0, 15) == 0);
            isSt = ($urandom_range(0, 1) == 1);
            applyStimulus(d, both | !isSt, both | isSt, addr, $urandom,
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), got);
         end
      end

      // Asynchronous reset during WAIT
      @(negedge clk);
      drive(1, 1'b0, 1'b1, BASE1 + SPAN, 32'h0BADF00D, 4'hF, 1'b0);
      @(negedge clk);
      driveIdle(1);
      checkOutput("t6_busy_wait", 32'(busy1), 32'h1);
      checkOutput("t6_err_set", 32'(err1), 32'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_async_busy", {30'h0, busy1, busy0}, 32'h0);
      checkOutput("t6_async_err", {30'h0, err1, err0}, 32'h0);
      checkOutput("t6_async_done", {30'h0, ifB.dm_load_done, ifB.dm_store_done}, 32'h0);
      checkOutput("t6_async_data", ifB.dm_data_l, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      expErr[0] = 1'b0;
      expErr[1] = 1'b0;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ifB.dm_load_done !== 1'b0 || ifB.dm_store_done !== 1'b0 || busy1 !== 1'b0) extra++;
      end
      checkOutput("t6_no_done", 32'(extra), 32'h0);
      applyStimulus(1, 1'b1, 1'b0, BASE1 + 32'h14, 32'h0, 4'h0, 1'b0, got);
      applyStimulus(1, 1'b1, 1'b0, BASE1 + 32'h18, 32'h0, 4'h0, 1'b0, got);
      applyStimulus(0, 1'b1, 1'b0, BASE0 + 32'h20, 32'h0, 4'h0, 1'b0, got);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
